// File: rtl/dadda_row_skid_buffer.sv
// Two-entry skid buffer that registers the Dadda tree's reduced rows and tag
// ahead of the final carry-select adder, with occupancy and stall reporting.
module dadda_row_skid_buffer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row_a,
    input  logic [WIDTH-1:0] in_row_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row_a,
    output logic [WIDTH-1:0] out_row_b,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_count
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_a_q, main_a_d;
    logic [WIDTH-1:0]   main_b_q, main_b_d;
    logic [TAG_W-1:0]   main_tag_q, main_tag_d;
    logic [WIDTH-1:0]   skid_a_q, skid_a_d;
    logic [WIDTH-1:0]   skid_b_q, skid_b_d;
    logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               accept;
    logic               rel;

    // Handshake terms come from registered state only, never from out_ready.
    assign in_ready    = (state_q != S_FULL) & ~flush;
    assign out_valid   = (state_q != S_EMPTY);
    assign accept      = in_valid & in_ready;
    assign rel         = out_valid & out_ready;

    assign out_row_a   = main_a_q;
    assign out_row_b   = main_b_q;
    assign out_tag     = main_tag_q;
    assign stall_count = stall_q;

    always_comb begin
        unique case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and datapath moves; flush overrides the state transition.
    always_comb begin
        state_d    = state_q;
        main_a_d   = main_a_q;
        main_b_d   = main_b_q;
        main_tag_d = main_tag_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_tag_d = skid_tag_q;

        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_a_d   = in_row_a;
                    main_b_d   = in_row_b;
                    main_tag_d = in_tag;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && rel) begin
                    main_a_d   = in_row_a;
                    main_b_d   = in_row_b;
                    main_tag_d = in_tag;
                end else if (accept) begin
                    skid_a_d   = in_row_a;
                    skid_b_d   = in_row_b;
                    skid_tag_d = in_tag;
                    state_d    = S_FULL;
                end else if (rel) begin
                    state_d    = S_EMPTY;
                end
            end
            S_FULL: begin
                if (rel) begin
                    main_a_d   = skid_a_q;
                    main_b_d   = skid_b_q;
                    main_tag_d = skid_tag_q;
                    state_d    = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    // Stall counter saturates and survives flush.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_tag_q <= '0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_tag_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_a_q   <= main_a_d;
            main_b_q   <= main_b_d;
            main_tag_q <= main_tag_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            skid_tag_q <= skid_tag_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_dadda_row_skid_buffer.sv
// Scoreboard bench for dadda_row_skid_buffer: a FIFO-queue reference model
// tracks accepted pairs; a forked monitor checks outputs every cycle.
module tb_dadda_row_skid_buffer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_row_a;
    logic [WIDTH-1:0] in_row_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_row_a;
    logic [WIDTH-1:0] out_row_b;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;
    logic [15:0]      stall_count;

    dadda_row_skid_buffer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row_a   (in_row_a),
        .in_row_b   (in_row_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row_a  (out_row_a),
        .out_row_b  (out_row_b),
        .out_tag    (out_tag),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pair_t       exp_q[$];
    int          n_tests;
    int          n_fail;
    int unsigned model_stall;
    bit          mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the scoreboard is updated at the edge the DUT acts on.
    task automatic cycle(input logic v, input pair_t p, input logic ordy, input logic fl,
                         output bit acc);
        in_valid  = v;
        in_row_a  = p.a;
        in_row_b  = p.b;
        in_tag    = p.tag;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(p);
        #1;
    endtask

    function automatic pair_t rand_pair();
        pair_t p;
        p.a   = WIDTH'($urandom);
        p.b   = WIDTH'($urandom);
        p.tag = TAG_W'($urandom);
        return p;
    endfunction

    initial begin
        pair_t       p;
        pair_t       p3;
        bit          acc;
        int          sz;
        int unsigned stall0;

        n_tests = 0; n_fail = 0; model_stall = 0; mon_en = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_row_a = 24'h5A5A5A; in_row_b = 24'hA5A5A5; in_tag = 4'hF;

        // Monitor: compares the DUT with the queue model whenever it presents data.
        fork
            forever begin
                @(negedge clk);
                sz = exp_q.size();
                if (mon_en) begin
                    check("occupancy", 32'(occupancy), 32'(sz));
                    check("out_valid", 32'(out_valid), 32'(sz != 0));
                    check("in_ready", 32'(in_ready), 32'((sz < 2) && !flush));
                    check("stall_count", 32'(stall_count), 32'(model_stall));
                    if (out_valid && sz > 0) begin
                        check("out_row_a", 32'(out_row_a), 32'(exp_q[0].a));
                        check("out_row_b", 32'(out_row_b), 32'(exp_q[0].b));
                        check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
                    end
                end
                if (rst_n && sz != 0 && !out_ready && model_stall < 32'hFFFF) model_stall++;
                if (rst_n && sz != 0 && out_ready) void'(exp_q.pop_front());
            end
        join_none

        // Reset with in_valid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_row_a", 32'(out_row_a), 32'd0);
        check("rst_out_row_b", 32'(out_row_b), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;

        // Streaming with out_ready held high
        for (int i = 0; i < 8; i++) begin
            p.a = WIDTH'(i + 1); p.b = 24'hFFFFF0 + WIDTH'(i); p.tag = TAG_W'(i);
            cycle(1'b1, p, 1'b1, 1'b0, acc);
            check("stream_accept", 32'(acc), 32'd1);
        end
        repeat (2) cycle(1'b0, p, 1'b1, 1'b0, acc);
        check("stream_stall", 32'(stall_count), 32'd0);

        // Back-pressure: fill to two entries, third pair must wait
        stall0 = 32'(stall_count);
        p.a = 24'h123456; p.b = 24'h000111; p.tag = 4'd1;
        cycle(1'b1, p, 1'b0, 1'b0, acc);
        p.a = 24'hABCDEF; p.b = 24'h000222; p.tag = 4'd2;
        cycle(1'b1, p, 1'b0, 1'b0, acc);
        p3.a = 24'h0F0F0F; p3.b = 24'h000333; p3.tag = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, p3, 1'b0, 1'b0, acc);
            check("bp_no_accept", 32'(acc), 32'd0);
        end
        check("bp_occupancy", 32'(occupancy), 32'd2);
        check("bp_stall_delta", 32'(stall_count) - stall0, 32'd4);
        acc = 0;
        for (int i = 0; i < 5 && !acc; i++) cycle(1'b1, p3, 1'b1, 1'b0, acc);
        check("bp_third_accepted", 32'(acc), 32'd1);
        repeat (3) cycle(1'b0, p3, 1'b1, 1'b0, acc);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_pair(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), acc);
        end
        repeat (3) cycle(1'b0, p, 1'b1, 1'b0, acc);

        // Flush while full, with a pair offered
        cycle(1'b1, rand_pair(), 1'b0, 1'b0, acc);
        cycle(1'b1, rand_pair(), 1'b0, 1'b0, acc);
        check("fl_full", 32'(occupancy), 32'd2);
        stall0 = 32'(stall_count);
        cycle(1'b1, rand_pair(), 1'b0, 1'b1, acc);
        check("fl_no_accept", 32'(acc), 32'd0);
        check("fl_occupancy", 32'(occupancy), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_stall_kept", 32'(stall_count), stall0 + 32'd1);
        cycle(1'b0, p, 1'b1, 1'b0, acc);

        // Saturation of the stall counter
        p.a = 24'hC0FFEE; p.b = 24'h0BEEF0; p.tag = 4'd9;
        cycle(1'b1, p, 1'b0, 1'b0, acc);
        mon_en = 0;
        repeat (65600) cycle(1'b0, p, 1'b0, 1'b0, acc);
        check("sat_stall", 32'(stall_count), 32'hFFFF);
        check("sat_hold_a", 32'(out_row_a), 32'hC0FFEE);
        check("sat_hold_tag", 32'(out_tag), 32'd9);
        mon_en = 1;
        repeat (5) cycle(1'b0, p, 1'b0, 1'b0, acc);
        check("sat_stays", 32'(stall_count), 32'hFFFF);
        repeat (2) cycle(1'b0, p, 1'b1, 1'b0, acc);
        check("end_empty", 32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
